inst_align: RTL and testbench

- Fetch-stage instruction fetcher/aligner sitting directly downstream of the PC controller.
- Takes the current 64-bit pc and fetches aligned 32-bit words from the instruction memory port.
- Extracts the 16-bit (RVC) or 32-bit instruction at pc, including 32-bit instructions straddling a word boundary.
- Drives inst_valid / inst_compressed back to the PC controller, and inst / inst_pc onward to decode.

---
 rtl/inst_align_if.sv | 31 +++
 rtl/inst_align.sv | 177 +++++++++++++++++
 tb/tb_inst_align.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_align_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : inst_align_if
// Description : Instruction-memory read port between fetch aligner and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_align_if #(
  parameter int ADDR_W = 64
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [31:0]       fetch_data;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ack,
    input  fetch_data
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ack,
    output fetch_data
  );
endinterface

`default_nettype wire

// File: rtl/inst_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : inst_align
// Description : Fetches aligned words and extracts the RVC/32-bit instruction
//               at pc, including 32-bit instructions straddling two words.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_align #(
  parameter int ADDR_W = 64
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [ADDR_W-1:0] i_pc,
  input  wire logic              i_flush,
  inst_align_if.master           fetch,
  output logic                   o_inst_valid,
  output logic                   o_inst_compressed,
  output logic [31:0]            o_inst,
  output logic [ADDR_W-1:0]      o_inst_pc
);

  localparam int TAG_W = ADDR_W - 2;
  localparam logic [TAG_W-1:0] C_TAG_ONE = {{(TAG_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_fetch_req;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic              w_req_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_wb_load;

  logic              r_wb_valid;
  logic [TAG_W-1:0]  r_wb_tag;
  logic [31:0]       r_wb_data;

  logic              r_sp_valid;
  logic [TAG_W-1:0]  r_sp_tag;
  logic [15:0]       r_sp_half;

  logic [TAG_W-1:0]  w_word;
  logic [TAG_W-1:0]  w_need;
  logic              w_spill_hit;
  logic              w_hit;
  logic [15:0]       w_lo;
  logic [15:0]       w_hi;
  logic              w_lo_rvc;
  logic              w_hi_rvc;
  logic              w_spill_cap;
  logic              w_unused_pc0;

  assign w_word       = i_pc[ADDR_W-1:2];
  assign w_unused_pc0 = i_pc[0];
  assign w_spill_hit  = r_sp_valid & (r_sp_tag == w_word) & i_pc[1];
  // A straddling instruction already has its low half parked, so it needs the next word.
  assign w_need       = w_spill_hit ? (w_word + C_TAG_ONE) : w_word;
  assign w_hit        = r_wb_valid & (r_wb_tag == w_need);
  assign w_lo         = r_wb_data[15:0];
  assign w_hi         = r_wb_data[31:16];
  assign w_lo_rvc     = (w_lo[1:0] != 2'b11);
  assign w_hi_rvc     = (w_hi[1:0] != 2'b11);

  assign o_inst_pc        = i_pc;
  assign fetch.fetch_req  = r_fetch_req;
  assign fetch.fetch_addr = r_fetch_addr;

  always_comb begin
    o_inst_valid      = 1'b0;
    o_inst_compressed = 1'b0;
    o_inst            = 32'h0;
    w_spill_cap       = 1'b0;
    if (w_hit && !i_flush) begin
      if (w_spill_hit) begin
        o_inst_valid = 1'b1;
        o_inst       = {w_lo, r_sp_half};
      end else if (!i_pc[1]) begin
        o_inst_valid = 1'b1;
        if (w_lo_rvc) begin
          o_inst            = {16'h0, w_lo};
          o_inst_compressed = 1'b1;
        end else begin
          o_inst = r_wb_data;
        end
      end else if (w_hi_rvc) begin
        o_inst_valid      = 1'b1;
        o_inst            = {16'h0, w_hi};
        o_inst_compressed = 1'b1;
      end else begin
        w_spill_cap = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_fetch_req;
    w_addr_nxt  = r_fetch_addr;
    w_wb_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_hit && !i_flush) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = {w_need, 2'b00};
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fetch.fetch_ack) begin
          w_req_nxt   = 1'b0;
          w_wb_load   = !i_flush;
          w_state_nxt = ST_IDLE;
        end else if (i_flush) begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        // The redirected pc must wait until the orphaned response has drained.
        if (fetch.fetch_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_fetch_req  <= 1'b0;
      r_fetch_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_req  <= w_req_nxt;
      r_fetch_addr <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_tag   <= '0;
      r_wb_data  <= 32'h0;
      r_sp_valid <= 1'b0;
      r_sp_tag   <= '0;
      r_sp_half  <= 16'h0;
    end else if (i_flush) begin
      r_wb_valid <= 1'b0;
      r_sp_valid <= 1'b0;
    end else begin
      if (w_wb_load) begin
        r_wb_valid <= 1'b1;
        r_wb_tag   <= r_fetch_addr[ADDR_W-1:2];
        r_wb_data  <= fetch.fetch_data;
      end
      if (w_spill_cap) begin
        r_sp_valid <= 1'b1;
        r_sp_tag   <= w_word;
        r_sp_half  <= w_hi;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_inst_align
// Description : Scoreboard bench for inst_align with a lazy random memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_align;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [63:0]       pc;
  logic              flush;
  logic              o_inst_valid;
  logic              o_inst_compressed;
  logic [31:0]       o_inst;
  logic [63:0]       o_inst_pc;

  inst_align_if #(.ADDR_W(ADDR_W)) bus ();

  inst_align #(.ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_pc              (pc),
    .i_flush           (flush),
    .fetch             (bus),
    .o_inst_valid      (o_inst_valid),
    .o_inst_compressed (o_inst_compressed),
    .o_inst            (o_inst),
    .o_inst_pc         (o_inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        comp;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb_q[$];
  exp_t        last_exp;
  bit          have_last = 0;
  logic [31:0] last_dut_inst;
  logic        last_dut_comp;
  logic [63:0] last_dut_pc;
  logic [31:0] mem [longint unsigned];
  logic [63:0] req_log[$];
  int          lat = 2;
  bit          rand_lat = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [15:0] h[2];
    for (int i = 0; i < 2; i++) begin
      h[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h[i][1:0] = 2'b11;
      else if (h[i][1:0] == 2'b11) h[i][1:0] = 2'b00;
    end
    return {h[1], h[0]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] widx);
    if (!mem.exists(widx)) mem[widx] = rand_word();
    return mem[widx];
  endfunction

  function automatic logic [15:0] half_at(input logic [63:0] a);
    logic [31:0] w;
    w = mem_word(a >> 2);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference: the instruction at byte address a, straight from memory contents.
  function automatic exp_t model(input logic [63:0] a);
    exp_t        e;
    logic [15:0] h0;
    h0   = half_at(a);
    e.pc = a;
    if (h0[1:0] != 2'b11) begin
      e.inst = {16'h0, h0};
      e.comp = 1'b1;
    end else begin
      e.inst = {half_at(a + 64'd2), h0};
      e.comp = 1'b0;
    end
    return e;
  endfunction

  // Memory responder
  initial begin
    int          cnt;
    logic [63:0] base;
    cnt = 0;
    base = '0;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.fetch_ack = 1'b0;
        cnt = 0;
      end else if (bus.fetch_ack) begin
        bus.fetch_ack = 1'b0;
        cnt = 0;
      end else if (bus.fetch_req) begin
        cnt++;
        if (cnt == 1) begin
          base = bus.fetch_addr;
          req_log.push_back(base);
          chk("fetch_addr aligned", {62'h0, bus.fetch_addr[1:0]}, 64'h0);
        end else begin
          chk("fetch_addr stable", bus.fetch_addr, base);
        end
        if (cnt >= lat) begin
          bus.fetch_ack  = 1'b1;
          bus.fetch_data = mem_word(bus.fetch_addr >> 2);
          if (rand_lat) lat = $urandom_range(1, 4);
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1) begin
      if (flush && o_inst_valid) begin
        chk("valid during flush", {63'h0, o_inst_valid}, 64'h0);
      end else if (o_inst_valid) begin
        last_dut_inst = o_inst;
        last_dut_comp = o_inst_compressed;
        last_dut_pc   = o_inst_pc;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          last_exp  = e;
          have_last = 1;
        end else begin
          e = last_exp;
        end
        if (!have_last) begin
          chk("unexpected valid", {63'h0, o_inst_valid}, 64'h0);
        end else begin
          chk("inst_pc", o_inst_pc, e.pc);
          chk("inst", {32'h0, o_inst}, {32'h0, e.inst});
          chk("inst_compressed", {63'h0, o_inst_compressed}, {63'h0, e.comp});
        end
      end
    end
  end

  task automatic set_pc(input logic [63:0] a, input bit fl);
    if (fl) sb_q.delete();
    pc    = a;
    flush = fl;
    sb_q.push_back(model(a));
    if (fl) begin
      @(posedge clk); #1;
      flush = 1'b0;
    end
  endtask

  task automatic wait_valid(input string name, input int budget, output int cycles);
    cycles = 0;
    while (sb_q.size() != 0 && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (sb_q.size() != 0) begin
      chk({name, " timeout"}, 64'h0, 64'h1);
      sb_q.delete();
    end
  endtask

  task automatic wait_req(input string name);
    int c = 0;
    while (!bus.fetch_req && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, " req issued"}, {63'h0, bus.fetch_req}, 64'h1);
  endtask

  initial begin
    int          cyc;
    int          n0;
    logic [63:0] tgt;
    rst_n = 1'b0;
    pc    = 64'h1000;
    flush = 1'b0;
    mem[64'h1000 >> 2] = 32'h00000513;
    mem[64'h3000 >> 2] = 32'h45814501;
    mem[64'h4000 >> 2] = 32'h05130001;
    mem[64'h4004 >> 2] = 32'h00010000;

    @(negedge clk);
    chk("reset fetch_req", {63'h0, bus.fetch_req}, 64'h0);
    chk("reset fetch_addr", bus.fetch_addr, 64'h0);
    chk("reset inst_valid", {63'h0, o_inst_valid}, 64'h0);
    chk("reset inst", {32'h0, o_inst}, 64'h0);
    chk("reset inst_compressed", {63'h0, o_inst_compressed}, 64'h0);

    // Cold start, latency 2
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.push_back(model(64'h1000));
    wait_valid("t1", 40, cyc);
    chk("t1 latency", 64'(cyc), 64'd4);
    chk("t1 req count", 64'(req_log.size()), 64'd1);
    chk("t1 req addr", req_log[0], 64'h1000);
    chk("t1 inst", {32'h0, last_dut_inst}, 64'h00000513);
    chk("t1 comp", {63'h0, last_dut_comp}, 64'h0);

    // Two RVC halves of one word, single request
    n0 = req_log.size();
    set_pc(64'h3000, 1);
    wait_valid("t2a", 40, cyc);
    chk("t2 inst lo", {32'h0, last_dut_inst}, 64'h00004501);
    set_pc(64'h3002, 0);
    wait_valid("t2b", 40, cyc);
    chk("t2 inst hi", {32'h0, last_dut_inst}, 64'h00004581);
    chk("t2 comp", {63'h0, last_dut_comp}, 64'h1);
    chk("t2 single req", 64'(req_log.size()), 64'(n0 + 1));

    // Straddling 32-bit instruction
    n0 = req_log.size();
    set_pc(64'h4002, 1);
    wait_valid("t3", 40, cyc);
    chk("t3 req count", 64'(req_log.size()), 64'(n0 + 2));
    if (req_log.size() >= n0 + 2) begin
      chk("t3 req0", req_log[n0], 64'h4000);
      chk("t3 req1", req_log[n0+1], 64'h4004);
    end
    chk("t3 inst", {32'h0, last_dut_inst}, 64'h00000513);
    chk("t3 comp", {63'h0, last_dut_comp}, 64'h0);
    chk("t3 inst_pc", last_dut_pc, 64'h4002);

    // Flush while waiting: response drained before the redirect fetch
    lat = 4;
    set_pc(64'h5000, 1);
    wait_req("t4");
    n0 = req_log.size();
    set_pc(64'h6000, 1);
    cyc = 0;
    while (bus.fetch_req && cyc < 20) begin
      chk("t4 addr held", bus.fetch_addr, 64'h5000);
      @(posedge clk); #1;
      cyc++;
    end
    lat = 2;
    wait_valid("t4", 40, cyc);
    chk("t4 req count", 64'(req_log.size()), 64'(n0 + 1));
    if (req_log.size() > n0) chk("t4 redirect addr", req_log[n0], 64'h6000);

    // Flush coincident with fetch_ack
    set_pc(64'h7000, 1);
    cyc = 0;
    do begin
      @(posedge clk); #2;
      cyc++;
    end while (!bus.fetch_ack && cyc < 20);
    chk("t5 ack seen", {63'h0, bus.fetch_ack}, 64'h1);
    set_pc(64'h8000, 1);
    chk("t5 req dropped", {63'h0, bus.fetch_req}, 64'h0);
    @(posedge clk); #1;
    chk("t5 new req", {63'h0, bus.fetch_req}, 64'h1);
    chk("t5 new addr", bus.fetch_addr, 64'h8000);
    wait_valid("t5", 40, cyc);

    // Asynchronous reset during an outstanding request
    set_pc(64'h1000, 1);
    wait_req("t6");
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 req cleared", {63'h0, bus.fetch_req}, 64'h0);
    chk("t6 valid cleared", {63'h0, o_inst_valid}, 64'h0);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = req_log.size();
    sb_q.push_back(model(64'h1000));
    wait_valid("t6", 40, cyc);
    chk("t6 req count", 64'(req_log.size()), 64'(n0 + 1));
    if (req_log.size() > n0) chk("t6 req addr", req_log[n0], 64'h1000);

    // Random instruction streams with redirects, stalls and latencies
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 12) begin
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        tgt = 64'h2000 + 64'(2 * $urandom_range(0, 127));
        set_pc(tgt, 1);
      end else begin
        wait_valid("rand", 100, cyc);
        if (r < 20) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        set_pc(pc + (last_exp.comp ? 64'd2 : 64'd4), 0);
      end
    end
    wait_valid("final", 100, cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
